// File: rtl/melody_player.sv
// melody_player: steps through a small note memory and drives a phase
// generator. Each entry is {duration in ticks, phase_delta}. A zero
// duration ends the song, and so does wrapping past the last entry.
// The song either finishes with a done pulse or restarts from entry 0.
module melody_player #(
  parameter int TICK_DIV  = 250_000,
  parameter int ADDR_W    = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [39:0]       i_wr_data,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic [31:0]       o_phase_delta,
  output logic              o_phase_delta_valid,
  output logic              o_gate,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [7:0]        GAP_L    = 8'(GAP_TICKS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] PLAY  = 2'd3;

  // Output handshake: o_phase_delta_valid is a single-cycle strobe with
  // no back-pressure. It is high in exactly the cycle in which
  // o_phase_delta first shows a newly written value (even if that value
  // did not change), and the consumer must take it in that cycle.

  logic [39:0]       mem [DEPTH];
  logic [39:0]       rd_data;
  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [PRE_W-1:0]  pre, pre_n;
  logic [7:0]        rem, rem_n;
  logic              wrap_end, wrap_n;
  logic [31:0]       delta_n;
  logic              valid_n, gate_n, done_n, tick;
  logic [7:0]        rd_dur;
  logic [31:0]       rd_delta;

  assign rd_dur      = rd_data[39:32];
  assign rd_delta    = rd_data[31:0];
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

  // Note memory: writes only while idle, synchronous read of the current
  // address. Contents are deliberately untouched by reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (state == IDLE)) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    rd_data <= mem[addr];
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    pre_n   = pre;
    rem_n   = rem;
    wrap_n  = wrap_end;
    delta_n = o_phase_delta;
    valid_n = 1'b0;
    done_n  = 1'b0;
    tick    = (pre == PRE_MAX);
    case (state)
      IDLE: begin
        if (i_start) begin
          addr_n  = '0;
          wrap_n  = 1'b0;
          state_n = FETCH;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        // A wrapped address counts as an end marker regardless of contents.
        if ((rd_dur == 8'd0) || wrap_end) begin
          if (i_loop) begin
            addr_n  = '0;
            wrap_n  = 1'b0;
            state_n = FETCH;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            delta_n = '0;
            valid_n = 1'b1;
          end
        end else begin
          rem_n   = rd_dur;
          pre_n   = '0;
          delta_n = rd_delta;
          valid_n = 1'b1;
          state_n = PLAY;
        end
      end
      default: begin
        pre_n = tick ? '0 : pre + PRE_W'(1);
        if (tick) begin
          rem_n = rem - 8'd1;
          if (rem == 8'd1) begin
            addr_n  = addr + ADDR_W'(1);
            wrap_n  = (addr == ADDR_MAX);
            state_n = FETCH;
          end
        end
      end
    endcase
    // Abort wins over everything except a start issued while idle.
    if ((state != IDLE) && i_stop) begin
      state_n = IDLE;
      delta_n = '0;
      valid_n = 1'b1;
      done_n  = 1'b0;
    end
    // Gate is derived from the values the registers are about to hold so
    // that it lines up with the note exactly, with no extra cycle of lag.
    gate_n = (state_n == PLAY) && (delta_n != 32'd0) && (rem_n > GAP_L);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state               <= IDLE;
      addr                <= '0;
      pre                 <= '0;
      rem                 <= '0;
      wrap_end            <= 1'b0;
      o_phase_delta       <= '0;
      o_phase_delta_valid <= 1'b0;
      o_gate              <= 1'b0;
      o_done              <= 1'b0;
    end else begin
      state               <= state_n;
      addr                <= addr_n;
      pre                 <= pre_n;
      rem                 <= rem_n;
      wrap_end            <= wrap_n;
      o_phase_delta       <= delta_n;
      o_phase_delta_valid <= valid_n;
      o_gate              <= gate_n;
      o_done              <= done_n;
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with TICK_DIV=4, GAP_TICKS=1, ADDR_W=4.
// Cycle c is counted from the cycle in which i_start is held high (c=0);
// outputs are sampled 1 ns after each rising edge.
module tb_melody_player;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [3:0]  i_wr_addr = '0;
  logic [39:0] i_wr_data = '0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_loop = 1'b0;
  logic [31:0] o_phase_delta;
  logic        o_phase_delta_valid;
  logic        o_gate;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_dbg_state;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] D_A = 32'd75591;

  melody_player #(.TICK_DIV(4), .ADDR_W(4), .GAP_TICKS(1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .i_stop(i_stop), .i_loop(i_loop),
    .o_phase_delta(o_phase_delta), .o_phase_delta_valid(o_phase_delta_valid),
    .o_gate(o_gate), .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_note(input logic [3:0] a, input logic [7:0] dur, input logic [31:0] d);
    i_wr_en = 1'b1;
    i_wr_addr = a;
    i_wr_data = {dur, d};
    step();
    i_wr_en = 1'b0;
  endtask

  // Leaves the bench observing c=1 (the first FETCH cycle).
  task automatic kick_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic load_basic();
    write_note(4'd0, 8'd3, D_A);
    write_note(4'd1, 8'd2, 32'd0);
    write_note(4'd2, 8'd0, 32'd0);
  endtask

  task automatic test_reset();
    logic [36:0] got;
    i_reset = 1'b1;
    repeat (3) step();
    got = {o_phase_delta, o_phase_delta_valid, o_gate, o_busy, o_done, o_dbg_state == 2'd0};
    total++;
    if (got !== {32'd0, 4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", got, {32'd0, 4'b0000, 1'b1});
    end
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_basic_play();
    logic [35:0] got, exp;
    logic [31:0] ed;
    load_basic();
    kick_start();
    for (int c = 1; c <= 30; c++) begin
      ed  = (c >= 3 && c <= 16) ? D_A : 32'd0;
      exp = {ed, (c == 3 || c == 17 || c == 27), (c >= 3 && c <= 10),
             (c <= 26), (c == 27)};
      got = {o_phase_delta, o_phase_delta_valid, o_gate, o_busy, o_done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL basic_play c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c < 30) step();
    end
  endtask

  task automatic test_loop();
    logic [35:0] got, exp;
    logic [31:0] ed;
    i_loop = 1'b1;
    kick_start();
    for (int c = 1; c <= 32; c++) begin
      ed  = ((c >= 3 && c <= 16) || c >= 29) ? D_A : 32'd0;
      exp = {ed, (c == 3 || c == 17 || c == 29),
             ((c >= 3 && c <= 10) || c >= 29), 1'b1, 1'b0};
      got = {o_phase_delta, o_phase_delta_valid, o_gate, o_busy, o_done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL loop c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c == 27) begin
        total++;
        if (o_dbg_state !== 2'd1) begin
          bad++;
          $display("FAIL loop_refetch got=%0d exp=1", o_dbg_state);
        end
      end
      if (c < 32) step();
    end
    i_loop = 1'b0;
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL loop_stop busy=%b done=%b exp busy=0 done=0", o_busy, o_done);
    end
    step();
  endtask

  task automatic test_stop();
    logic [35:0] got;
    kick_start();
    repeat (5) step();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    got = {o_phase_delta, o_phase_delta_valid, o_gate, o_busy, o_done};
    total++;
    if (got !== {32'd0, 4'b1000}) begin
      bad++;
      $display("FAIL stop_c7 got=%h exp=%h", got, {32'd0, 4'b1000});
    end
    step();
    total++;
    if (o_phase_delta_valid !== 1'b0 || o_done !== 1'b0 || o_dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL stop_c8 valid=%b done=%b state=%0d exp 0 0 0",
               o_phase_delta_valid, o_done, o_dbg_state);
    end
    kick_start();
    step();
    step();
    total++;
    if ({o_phase_delta, o_phase_delta_valid, o_gate} !== {D_A, 2'b11}) begin
      bad++;
      $display("FAIL stop_replay delta=%0d valid=%b gate=%b exp %0d 1 1",
               o_phase_delta, o_phase_delta_valid, o_gate, D_A);
    end
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    step();
  endtask

  task automatic test_write_busy();
    kick_start();
    repeat (4) step();
    i_wr_en = 1'b1;
    i_wr_addr = 4'd0;
    i_wr_data = {8'd5, 32'd42};
    step();
    i_wr_en = 1'b0;
    repeat (3) step();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    step();
    kick_start();
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        total++;
        if (o_phase_delta !== D_A || o_phase_delta_valid !== 1'b1) begin
          bad++;
          $display("FAIL write_busy_delta got=%0d/%b exp=%0d/1",
                   o_phase_delta, o_phase_delta_valid, D_A);
        end
      end
      if (c == 10 || c == 11) begin
        total++;
        if (o_gate !== (c == 10)) begin
          bad++;
          $display("FAIL write_busy_gate c=%0d got=%b exp=%b", c, o_gate, c == 10);
        end
      end
      step();
    end
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    step();
  endtask

  task automatic test_short_note();
    logic [35:0] got, exp;
    logic [31:0] ed;
    write_note(4'd0, 8'd1, 32'd1000);
    write_note(4'd1, 8'd0, 32'd0);
    kick_start();
    for (int c = 1; c <= 10; c++) begin
      ed  = (c >= 3 && c <= 8) ? 32'd1000 : 32'd0;
      exp = {ed, (c == 3 || c == 9), 1'b0, (c <= 8), (c == 9)};
      got = {o_phase_delta, o_phase_delta_valid, o_gate, o_busy, o_done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL short_note c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c < 10) step();
    end
  endtask

  task automatic test_wrap();
    int pulses;
    logic [2:0] got, exp;
    for (int a = 0; a < 16; a++) write_note(4'(a), 8'd1, 32'd100);
    pulses = 0;
    kick_start();
    for (int c = 1; c <= 104; c++) begin
      if (o_phase_delta_valid) pulses++;
      got = {o_gate, o_busy, o_done};
      exp = {1'b0, (c <= 98), (c == 99)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL wrap c=%0d got=%b exp=%b", c, got, exp);
      end
      step();
    end
    total++;
    if (pulses != 17) begin
      bad++;
      $display("FAIL wrap_valid_count got=%0d exp=17", pulses);
    end
  endtask

  task automatic test_reset_mid_note();
    logic [36:0] got;
    load_basic();
    kick_start();
    repeat (4) step();
    total++;
    if (o_gate !== 1'b1 || o_phase_delta !== D_A) begin
      bad++;
      $display("FAIL pre_reset gate=%b delta=%0d exp 1 %0d", o_gate, o_phase_delta, D_A);
    end
    i_reset = 1'b1;
    i_start = 1'b1;
    i_stop = 1'b1;
    step();
    got = {o_phase_delta, o_phase_delta_valid, o_gate, o_busy, o_done, o_dbg_state == 2'd0};
    total++;
    if (got !== {32'd0, 4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_note got=%h exp=%h", got, {32'd0, 4'b0000, 1'b1});
    end
    i_reset = 1'b0;
    i_start = 1'b0;
    i_stop = 1'b0;
    step();
    kick_start();
    step();
    step();
    total++;
    if (o_phase_delta !== D_A || o_phase_delta_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_recover delta=%0d valid=%b exp %0d 1",
               o_phase_delta, o_phase_delta_valid, D_A);
    end
  endtask

  initial begin
    test_reset();
    test_basic_play();
    test_loop();
    test_stop();
    test_write_busy();
    test_short_note();
    test_wrap();
    test_reset_mid_note();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
